// File: rtl/spi_mst_mc.sv
// Multi-channel SPI master on the MCU peripheral bus: software chip selects, all
// four CPOL/CPHA modes, MSB/LSB-first and a maskable transfer-done interrupt.
module spi_mst_mc #(
    parameter int         NCS     = 2,
    parameter logic [7:0] DIV_RST = 8'd124
) (
    input  logic           clk_i,
    input  logic           mcu_rst_i,
    input  logic           mcu_cs_i,
    input  logic           mcu_wr_i,
    input  logic           mcu_rd_i,
    input  logic [7:0]     mcu_addr_i8,
    input  logic [7:0]     mcu_wrdat_i8,
    output logic [7:0]     mcu_rddat_o8,
    output logic           mcu_int_o,
    output logic           spi_sck_o,
    output logic           spi_mosi_o,
    input  logic           spi_miso_i,
    output logic [NCS-1:0] spi_ncs_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        DONE_ST = 2'd2
    } state_t;

    function automatic logic [7:0] bit_rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = v[7-i];
        end
        return r;
    endfunction

    logic           wr_meta_r, wr_sync_r, wr_prev_r;
    logic           rd_meta_r, rd_sync_r, rd_prev_r;
    logic           wr_pulse_s, rd_pulse_s;
    logic [3:0]     addr_s;
    logic           wr_data_s, wr_ctrl_s, wr_div_s, wr_cs_s, wr_stat_s, rd_data_s;
    logic [3:0]     ctrl_r;
    logic [7:0]     div_r;
    logic [NCS-1:0] cs_r;
    logic [7:0]     rx_r;
    logic           done_r, ovr_r, int_r;
    state_t         state_r, state_nxt_s;
    logic           busy_s, load_s, tick_s, finish_s;
    logic [7:0]     cnt_r;
    logic [4:0]     edge_r;
    logic [4:0]     edge_nxt_s;
    logic           lead_s, drive_s, sample_s;
    logic [7:0]     shift_r, rxsh_r, tx_val_s;
    logic           sck_r, mosi_r;
    logic [7:0]     rddat_s;
    logic           unused_addr_s;

    assign unused_addr_s = ^mcu_addr_i8[7:4];
    assign addr_s        = mcu_addr_i8[3:0];

    // Two-flop synchronisers plus edge detectors for the asynchronous bus strobes
    always_ff @(posedge clk_i or negedge mcu_rst_i) begin
        if (!mcu_rst_i) begin
            wr_meta_r <= 1'b0; wr_sync_r <= 1'b0; wr_prev_r <= 1'b0;
            rd_meta_r <= 1'b0; rd_sync_r <= 1'b0; rd_prev_r <= 1'b0;
        end else begin
            wr_meta_r <= mcu_wr_i & mcu_cs_i;
            wr_sync_r <= wr_meta_r;
            wr_prev_r <= wr_sync_r;
            rd_meta_r <= mcu_rd_i & mcu_cs_i;
            rd_sync_r <= rd_meta_r;
            rd_prev_r <= rd_sync_r;
        end
    end

    assign wr_pulse_s = wr_sync_r & ~wr_prev_r;
    assign rd_pulse_s = rd_sync_r & ~rd_prev_r;
    assign wr_data_s  = wr_pulse_s & (addr_s == 4'h0);
    assign wr_ctrl_s  = wr_pulse_s & (addr_s == 4'h1);
    assign wr_div_s   = wr_pulse_s & (addr_s == 4'h2);
    assign wr_cs_s    = wr_pulse_s & (addr_s == 4'h3);
    assign wr_stat_s  = wr_pulse_s & (addr_s == 4'h4);
    assign rd_data_s  = rd_pulse_s & (addr_s == 4'h0);

    // FSM state register
    always_ff @(posedge clk_i or negedge mcu_rst_i) begin
        if (!mcu_rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; the last half-period tick of edge 16 ends the shift
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (wr_data_s) state_nxt_s = SHIFT;
                else           state_nxt_s = IDLE;
            end
            SHIFT: begin
                if ((cnt_r == div_r) && (edge_r == 5'd15)) state_nxt_s = DONE_ST;
                else                                       state_nxt_s = SHIFT;
            end
            DONE_ST: state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM outputs; DONE_ST still counts as busy so a write landing there is refused
    always_comb begin
        busy_s   = 1'b0;
        load_s   = 1'b0;
        tick_s   = 1'b0;
        finish_s = 1'b0;
        case (state_r)
            IDLE:    load_s = wr_data_s;
            SHIFT: begin
                busy_s = 1'b1;
                tick_s = (cnt_r == div_r);
            end
            DONE_ST: begin
                busy_s   = 1'b1;
                finish_s = 1'b1;
            end
            default: busy_s = 1'b0;
        endcase
    end

    assign edge_nxt_s = edge_r + 5'd1;
    assign lead_s     = edge_nxt_s[0];
    assign drive_s    = tick_s & (ctrl_r[0] ? lead_s : (~lead_s & (edge_nxt_s != 5'd16)));
    assign sample_s   = tick_s & (ctrl_r[0] ? ~lead_s : lead_s);
    assign tx_val_s   = ctrl_r[2] ? bit_rev8(mcu_wrdat_i8) : mcu_wrdat_i8;

    // Shift datapath; with CPHA=0 bit 7 goes out at load, so the register is preshifted
    always_ff @(posedge clk_i or negedge mcu_rst_i) begin
        if (!mcu_rst_i) begin
            cnt_r   <= 8'd0;
            edge_r  <= 5'd0;
            shift_r <= 8'd0;
            rxsh_r  <= 8'd0;
            mosi_r  <= 1'b1;
            sck_r   <= 1'b0;
        end else if (load_s) begin
            cnt_r   <= 8'd0;
            edge_r  <= 5'd0;
            rxsh_r  <= 8'd0;
            sck_r   <= ctrl_r[1];
            if (ctrl_r[0]) begin
                shift_r <= tx_val_s;
            end else begin
                shift_r <= {tx_val_s[6:0], 1'b0};
                mosi_r  <= tx_val_s[7];
            end
        end else if (state_r == SHIFT) begin
            if (tick_s) begin
                cnt_r  <= 8'd0;
                edge_r <= edge_nxt_s;
                sck_r  <= ~sck_r;
            end else begin
                cnt_r  <= cnt_r + 8'd1;
            end
            if (drive_s) begin
                mosi_r  <= shift_r[7];
                shift_r <= {shift_r[6:0], 1'b0};
            end
            if (sample_s) begin
                rxsh_r <= {rxsh_r[6:0], spi_miso_i};
            end
        end else begin
            sck_r <= ctrl_r[1];
        end
    end

    // Configuration registers; CTRL/DIV are frozen during a transfer, CS never is
    always_ff @(posedge clk_i or negedge mcu_rst_i) begin
        if (!mcu_rst_i) begin
            ctrl_r <= 4'd0;
            div_r  <= DIV_RST;
            cs_r   <= '0;
        end else begin
            if (wr_ctrl_s && !busy_s) ctrl_r <= mcu_wrdat_i8[3:0];
            if (wr_div_s && !busy_s)  div_r  <= mcu_wrdat_i8;
            if (wr_cs_s)              cs_r   <= mcu_wrdat_i8[NCS-1:0];
        end
    end

    // Status flags, RX capture and interrupt; setting a flag wins over clearing it
    always_ff @(posedge clk_i or negedge mcu_rst_i) begin
        if (!mcu_rst_i) begin
            rx_r   <= 8'd0;
            done_r <= 1'b0;
            ovr_r  <= 1'b0;
            int_r  <= 1'b0;
        end else begin
            if (finish_s) rx_r <= ctrl_r[2] ? bit_rev8(rxsh_r) : rxsh_r;
            if (finish_s)       done_r <= 1'b1;
            else if (rd_data_s) done_r <= 1'b0;
            if ((wr_data_s | wr_ctrl_s | wr_div_s) && busy_s) ovr_r <= 1'b1;
            else if (wr_stat_s && mcu_wrdat_i8[2])            ovr_r <= 1'b0;
            int_r <= ctrl_r[3] & done_r;
        end
    end

    // Combinational read mux, quiet unless the CPU is actively reading this block
    always_comb begin
        rddat_s = 8'h00;
        if (mcu_cs_i && mcu_rd_i) begin
            case (addr_s)
                4'h0:    rddat_s = rx_r;
                4'h1:    rddat_s = {4'b0000, ctrl_r};
                4'h2:    rddat_s = div_r;
                4'h3:    rddat_s = 8'(cs_r);
                4'h4:    rddat_s = {5'b00000, ovr_r, done_r, busy_s};
                default: rddat_s = 8'h00;
            endcase
        end else begin
            rddat_s = 8'h00;
        end
    end

    assign mcu_rddat_o8 = rddat_s;
    assign mcu_int_o    = int_r;
    assign spi_sck_o    = sck_r;
    assign spi_mosi_o   = mosi_r;
    assign spi_ncs_o    = ~cs_r;

endmodule

// File: tb/tb_spi_mst_mc.sv
// Directed bench for spi_mst_mc: register access, SPI modes 0/3, LSB-first,
// interrupt, overrun handling and reset in the middle of a transfer.
module tb_spi_mst_mc;

    logic       clk_i = 1'b0;
    logic       mcu_rst_i = 1'b0;
    logic       mcu_cs_i = 1'b0;
    logic       mcu_wr_i = 1'b0;
    logic       mcu_rd_i = 1'b0;
    logic [7:0] mcu_addr_i8 = 8'h00;
    logic [7:0] mcu_wrdat_i8 = 8'h00;
    logic [7:0] mcu_rddat_o8;
    logic       mcu_int_o;
    logic       spi_sck_o;
    logic       spi_mosi_o;
    logic       spi_miso_i;
    logic [1:0] spi_ncs_o;
    logic       loop_en = 1'b1;
    logic       miso_tie = 1'b1;

    int         vectors = 0;
    int         miscompares = 0;
    int         sck_edges = 0;
    int         busy_cycles = 0;
    logic [7:0] mosi_log = 8'h00;
    logic [7:0] rd;

    assign spi_miso_i = loop_en ? spi_mosi_o : miso_tie;

    spi_mst_mc #(.NCS(2), .DIV_RST(8'd124)) dut (
        .clk_i(clk_i), .mcu_rst_i(mcu_rst_i), .mcu_cs_i(mcu_cs_i),
        .mcu_wr_i(mcu_wr_i), .mcu_rd_i(mcu_rd_i), .mcu_addr_i8(mcu_addr_i8),
        .mcu_wrdat_i8(mcu_wrdat_i8), .mcu_rddat_o8(mcu_rddat_o8), .mcu_int_o(mcu_int_o),
        .spi_sck_o(spi_sck_o), .spi_mosi_o(spi_mosi_o), .spi_miso_i(spi_miso_i),
        .spi_ncs_o(spi_ncs_o)
    );

    always #10 clk_i = ~clk_i;

    always @(spi_sck_o) sck_edges = sck_edges + 1;
    always @(posedge spi_sck_o) mosi_log = {mosi_log[6:0], spi_mosi_o};
    always @(negedge clk_i) if (dut.busy_s === 1'b1) busy_cycles = busy_cycles + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk_i);
        mcu_addr_i8 = a; mcu_wrdat_i8 = d; mcu_cs_i = 1'b1; mcu_wr_i = 1'b1;
        repeat (4) @(negedge clk_i);
        mcu_wr_i = 1'b0; mcu_cs_i = 1'b0;
        repeat (3) @(negedge clk_i);
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk_i);
        mcu_addr_i8 = a; mcu_cs_i = 1'b1; mcu_rd_i = 1'b1;
        #1 d = mcu_rddat_o8;
        repeat (4) @(negedge clk_i);
        mcu_rd_i = 1'b0; mcu_cs_i = 1'b0;
        repeat (3) @(negedge clk_i);
    endtask

    task automatic clear_mon();
        sck_edges = 0; busy_cycles = 0; mosi_log = 8'h00;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (dut.busy_s !== 1'b0 && n < 5000) begin
            @(posedge clk_i); #1; n++;
        end
        check(tag, 32'(n < 5000), 32'd1);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk_i);
        mcu_rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        check("rst_ncs", 32'(spi_ncs_o), 32'h3);
        check("rst_sck", 32'(spi_sck_o), 32'h0);
        check("rst_mosi", 32'(spi_mosi_o), 32'h1);
        check("rst_int", 32'(mcu_int_o), 32'h0);
        bus_read(8'h00, rd); check("rst_data", 32'(rd), 32'h00);
        bus_read(8'h01, rd); check("rst_ctrl", 32'(rd), 32'h00);
        bus_read(8'h02, rd); check("rst_div", 32'(rd), 32'h7C);
        bus_read(8'h03, rd); check("rst_cs", 32'(rd), 32'h00);
        bus_read(8'h04, rd); check("rst_status", 32'(rd), 32'h00);
        bus_read(8'h07, rd); check("unmapped", 32'(rd), 32'h00);

        // Mode 0, DIV=1, loopback, 0xA5
        bus_write(8'h01, 8'h00);
        bus_write(8'h02, 8'h01);
        bus_write(8'h03, 8'h01);
        check("m0_ncs", 32'(spi_ncs_o), 32'h2);
        loop_en = 1'b1;
        clear_mon();
        bus_write(8'h00, 8'hA5);
        wait_idle("m0_timeout");
        @(negedge clk_i);
        check("m0_edges", 32'(sck_edges), 32'd16);
        check("m0_busy", 32'(busy_cycles), 32'd33);
        check("m0_mosi", 32'(mosi_log), 32'hA5);
        check("m0_sck_end", 32'(spi_sck_o), 32'h0);
        bus_read(8'h04, rd); check("m0_status", 32'(rd), 32'h02);
        bus_read(8'h00, rd); check("m0_rx", 32'(rd), 32'hA5);
        bus_read(8'h04, rd); check("m0_done_clr", 32'(rd), 32'h00);

        // Mode 3, DIV=0, MISO tied high, 0x3C
        bus_write(8'h01, 8'h03);
        bus_write(8'h02, 8'h00);
        check("m3_sck_idle", 32'(spi_sck_o), 32'h1);
        loop_en = 1'b0; miso_tie = 1'b1;
        clear_mon();
        bus_write(8'h00, 8'h3C);
        wait_idle("m3_timeout");
        @(negedge clk_i);
        check("m3_edges", 32'(sck_edges), 32'd16);
        check("m3_busy", 32'(busy_cycles), 32'd17);
        check("m3_mosi", 32'(mosi_log), 32'h3C);
        check("m3_sck_end", 32'(spi_sck_o), 32'h1);
        bus_read(8'h00, rd); check("m3_rx", 32'(rd), 32'hFF);

        // LSB-first with interrupt enabled, 0x01
        bus_write(8'h01, 8'h0C);
        bus_read(8'h01, rd); check("lsb_ctrl", 32'(rd), 32'h0C);
        loop_en = 1'b1;
        clear_mon();
        bus_write(8'h00, 8'h01);
        begin
            int n;
            n = 0;
            while (dut.done_r !== 1'b1 && n < 5000) begin
                @(posedge clk_i); #1; n++;
            end
            check("lsb_timeout", 32'(n < 5000), 32'd1);
        end
        check("int_lag", 32'(mcu_int_o), 32'h0);
        @(posedge clk_i); #1;
        check("int_rise", 32'(mcu_int_o), 32'h1);
        check("lsb_mosi", 32'(mosi_log), 32'h80);
        bus_read(8'h00, rd); check("lsb_rx", 32'(rd), 32'h01);
        check("int_clear", 32'(mcu_int_o), 32'h0);

        // Overrun: DATA and DIV writes while busy
        bus_write(8'h01, 8'h00);
        bus_write(8'h02, 8'h03);
        clear_mon();
        bus_write(8'h00, 8'h5A);
        bus_write(8'h00, 8'hFF);
        bus_write(8'h02, 8'h00);
        wait_idle("ovr_timeout");
        repeat (5) @(negedge clk_i);
        check("ovr_idle", 32'(dut.busy_s), 32'h0);
        check("ovr_edges", 32'(sck_edges), 32'd16);
        check("ovr_busy", 32'(busy_cycles), 32'd65);
        check("ovr_mosi", 32'(mosi_log), 32'h5A);
        bus_read(8'h02, rd); check("ovr_div", 32'(rd), 32'h03);
        bus_read(8'h04, rd); check("ovr_status", 32'(rd), 32'h06);
        bus_write(8'h04, 8'h04);
        bus_read(8'h04, rd); check("ovr_clr", 32'(rd), 32'h02);
        bus_read(8'h00, rd); check("ovr_rx", 32'(rd), 32'h5A);

        // Reset after the fifth SCK edge
        clear_mon();
        bus_write(8'h00, 8'h96);
        begin
            int n;
            n = 0;
            while (sck_edges < 5 && n < 1000) begin
                @(posedge clk_i); #1; n++;
            end
            check("rst5_timeout", 32'(n < 1000), 32'd1);
        end
        #3 mcu_rst_i = 1'b0;
        #2;
        check("mid_sck", 32'(spi_sck_o), 32'h0);
        check("mid_ncs", 32'(spi_ncs_o), 32'h3);
        check("mid_mosi", 32'(spi_mosi_o), 32'h1);
        check("mid_busy", 32'(dut.busy_s), 32'h0);
        @(negedge clk_i);
        mcu_rst_i = 1'b1;
        bus_read(8'h00, rd); check("mid_rx", 32'(rd), 32'h00);
        bus_read(8'h04, rd); check("mid_status", 32'(rd), 32'h00);
        bus_read(8'h02, rd); check("mid_div", 32'(rd), 32'h7C);

        // Transfer after reset release
        bus_write(8'h02, 8'h01);
        bus_write(8'h03, 8'h01);
        clear_mon();
        bus_write(8'h00, 8'hC3);
        wait_idle("post_timeout");
        @(negedge clk_i);
        check("post_busy", 32'(busy_cycles), 32'd33);
        check("post_mosi", 32'(mosi_log), 32'hC3);
        bus_read(8'h00, rd); check("post_rx", 32'(rd), 32'hC3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
